// File: rtl/hdr_done_sequencer.sv
// rtl/hdr_done_sequencer.sv - bounded in-order issue/completion sequencer for the header accumulator
`timescale 1ns/1ps
module hdr_done_sequencer #(
    parameter int OUTSTANDING_BITS = 4,
    parameter int TIMEOUT_CYCLES   = 1000000,
    parameter int TIMEOUT_BITS     = 24
) (
    input  logic                        memclk,
    input  logic                        memrst,
    input  logic                        enable_i,
    input  logic                        clear_i,
    input  logic [12:0]                 s_addr_tdata,
    input  logic                        s_addr_tvalid,
    output logic                        s_addr_tready,
    output logic [15:0]                 m_done_tdata,
    output logic                        m_done_tvalid,
    input  logic                        m_done_tready,
    input  logic [23:0]                 s_cmpl_tdata,
    input  logic                        s_cmpl_tvalid,
    output logic                        s_cmpl_tready,
    output logic [23:0]                 m_ack_tdata,
    output logic                        m_ack_tvalid,
    input  logic                        m_ack_tready,
    output logic [OUTSTANDING_BITS:0]   outstanding_o,
    output logic [15:0]                 err_count_o,
    output logic                        order_err_o,
    output logic                        timeout_o
);
    localparam int MAX_OUTSTANDING = 2 ** OUTSTANDING_BITS;
    localparam logic [OUTSTANDING_BITS:0] MAX_OUT  = (OUTSTANDING_BITS + 1)'(MAX_OUTSTANDING);
    localparam logic [TIMEOUT_BITS-1:0]   TO_LIMIT = TIMEOUT_BITS'(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_BITS-1:0]   TO_LAST  = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {ST_RUN, ST_HALT} state_t;
    state_t state, state_next;

    logic [12:0]                 tag_mem [MAX_OUTSTANDING];
    logic [OUTSTANDING_BITS-1:0] wr_ptr, rd_ptr;
    logic [OUTSTANDING_BITS:0]   outstanding;
    logic [TIMEOUT_BITS-1:0]     to_cnt;

    logic        addr_hs, cmpl_hs, fifo_empty, push, pop;
    logic        to_clear, timeout_fire, mismatch;
    logic [12:0] cmpl_addr, head_addr, ack_tag;
    logic [3:0]  cmpl_err;
    logic        unused_cmpl_bits;

    assign cmpl_addr        = s_cmpl_tdata[20:8];
    assign cmpl_err         = s_cmpl_tdata[3:0];
    assign unused_cmpl_bits = ^{s_cmpl_tdata[23:21], s_cmpl_tdata[7:4]};

    // Issue is gated on the registered count only; a completion in the same cycle gives no credit.
    assign s_addr_tready = !memrst && (state == ST_RUN) && enable_i &&
                           (outstanding < MAX_OUT) && (!m_done_tvalid || m_done_tready);
    // Completions keep draining in HALT so software can recover the pipeline.
    assign s_cmpl_tready = !memrst && (!m_ack_tvalid || m_ack_tready);

    assign addr_hs    = s_addr_tvalid && s_addr_tready;
    assign cmpl_hs    = s_cmpl_tvalid && s_cmpl_tready;
    assign fifo_empty = (outstanding == '0);
    assign push       = addr_hs;
    assign pop        = cmpl_hs && !fifo_empty;
    assign head_addr  = tag_mem[rd_ptr];
    assign mismatch   = fifo_empty || (head_addr != cmpl_addr);
    assign ack_tag    = fifo_empty ? cmpl_addr : head_addr;

    // Clear wins over a coincident timeout, so clear_i is folded into the counter clear term.
    assign to_clear     = clear_i || cmpl_hs || fifo_empty;
    assign timeout_fire = (state == ST_RUN) && !to_clear && (to_cnt == TO_LAST);

    assign outstanding_o = outstanding;

    // State register
    always_ff @(posedge memclk) begin
        if (memrst) state <= ST_RUN;
        else        state <= state_next;
    end

    // Next-state: halt on timeout, resume only when software clears
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:  if (timeout_fire) state_next = ST_HALT;
            ST_HALT: if (clear_i)      state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    // Tag FIFO storage; contents are don't-care until written, pointers carry validity
    always_ff @(posedge memclk) begin
        if (push) tag_mem[wr_ptr] <= s_addr_tdata;
    end

    // Tag FIFO pointers and outstanding count
    always_ff @(posedge memclk) begin
        if (memrst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Done output register: holds the beat until accepted regardless of halt/enable
    always_ff @(posedge memclk) begin
        if (memrst) begin
            m_done_tvalid <= 1'b0;
            m_done_tdata  <= '0;
        end else if (addr_hs) begin
            m_done_tvalid <= 1'b1;
            m_done_tdata  <= {3'b000, s_addr_tdata};
        end else if (m_done_tready) begin
            m_done_tvalid <= 1'b0;
        end
    end

    // Ack output register carrying the expected tag, mismatch flag and error code
    always_ff @(posedge memclk) begin
        if (memrst) begin
            m_ack_tvalid <= 1'b0;
            m_ack_tdata  <= '0;
        end else if (cmpl_hs) begin
            m_ack_tvalid <= 1'b1;
            m_ack_tdata  <= {3'b000, ack_tag, 3'b000, mismatch, cmpl_err};
        end else if (m_ack_tready) begin
            m_ack_tvalid <= 1'b0;
        end
    end

    // Stall timer: counts cycles with work outstanding and no completion, saturating
    always_ff @(posedge memclk) begin
        if (memrst || to_clear)     to_cnt <= '0;
        else if (to_cnt != TO_LIMIT) to_cnt <= to_cnt + 1'b1;
    end

    // Sticky status; a new error event in the clear cycle is still recorded
    always_ff @(posedge memclk) begin
        if (memrst) begin
            err_count_o <= '0;
            order_err_o <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            if (clear_i)
                err_count_o <= {15'd0, cmpl_hs && (cmpl_err != 4'd0)};
            else if (cmpl_hs && (cmpl_err != 4'd0) && (err_count_o != 16'hFFFF))
                err_count_o <= err_count_o + 16'd1;
            order_err_o <= (order_err_o && !clear_i) || (cmpl_hs && mismatch);
            timeout_o   <= (timeout_o && !clear_i) || timeout_fire;
        end
    end
endmodule

// File: doc/hdr_done_sequencer.md
Name: hdr_done_sequencer

Overview:
- Sits in memclk domain in front of the header accumulator.
- Issues event-buffer addresses to the accumulator's done (address) stream and bounds outstanding headers to MAX_OUTSTANDING.
- Tracks issued addresses in an in-order tag FIFO, matches returning completions against it and forwards acknowledged addresses downstream.
- Detects out-of-order/unexpected completions and stalled completions (timeout); halts issue on timeout until software clears.

Parameters:
- OUTSTANDING_BITS, 4, log2 of tag FIFO depth; MAX_OUTSTANDING = 2**OUTSTANDING_BITS.
- TIMEOUT_CYCLES, 1000000, memclk cycles with outstanding>0 and no completion before timeout.
- TIMEOUT_BITS, 24, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- memclk  in  1  clock
- memrst  in  1  synchronous active-high reset
- enable_i  in  1  1 = issue permitted; 0 = drain only
- clear_i  in  1  one-cycle pulse: clear sticky flags, err_count_o, leave HALT
- s_addr_tdata  in  13  event buffer address to process
- s_addr_tvalid  in  1
- s_addr_tready  out  1
- m_done_tdata  out  16  {3'b0, addr[12:0]} to accumulator
- m_done_tvalid  out  1
- m_done_tready  in  1
- s_cmpl_tdata  in  24  {3'b0, addr[12:0], 4'b0, err[3:0]} from accumulator
- s_cmpl_tvalid  in  1
- s_cmpl_tready  out  1
- m_ack_tdata  out  24  {3'b0, tag_addr[12:0], 3'b0, mismatch, err[3:0]}
- m_ack_tvalid  out  1
- m_ack_tready  in  1
- outstanding_o  out  OUTSTANDING_BITS+1  issued minus completed
- err_count_o  out  16  completions with err!=0, saturating
- order_err_o  out  1  sticky: completion addr != tag FIFO head, or completion with FIFO empty
- timeout_o  out  1  sticky: timeout fired

Behaviour:
- Reset: all tvalid outputs 0, s_addr_tready 0, s_cmpl_tready 0, outstanding 0, counters 0, sticky flags 0, tag FIFO empty, state RUN.
- FSM: RUN, HALT. RUN->HALT when timeout counter reaches TIMEOUT_CYCLES (timeout_o set same edge). HALT->RUN on clear_i. memrst in any state -> RUN, all in-flight state discarded.
- Issue path: m_done is a single output register. s_addr_tready = state==RUN && enable_i && outstanding < MAX_OUTSTANDING && (!m_done_tvalid || m_done_tready). On s_addr handshake: load m_done_tdata, assert m_done_tvalid next cycle (latency 1), push addr to tag FIFO, outstanding+1. m_done_tvalid held until m_done_tready; data stable while valid. Entering HALT or enable_i low never drops an already-valid m_done beat.
- Completion path: m_ack is a single output register. s_cmpl_tready = !m_ack_tvalid || m_ack_tready (never gated by HALT, so drains continue). On s_cmpl handshake:
  - FIFO non-empty: pop head; tag_addr = head; mismatch = (head != s_cmpl addr); mismatch sets order_err_o; outstanding-1.
  - FIFO empty: no pop, outstanding unchanged; tag_addr = s_cmpl addr; mismatch = 1; order_err_o set.
  - err!=0 increments err_count_o, saturating at 16'hFFFF.
  - m_ack_tvalid asserted next cycle (latency 1).
- Simultaneous issue and completion in one cycle: push and pop both occur; outstanding unchanged. Issue is allowed at outstanding==MAX only if never; the limit is checked against the registered count (no same-cycle credit from a completion).
- Timeout counter: cleared on any completion handshake, when outstanding==0, or on clear_i; otherwise +1 per cycle, saturating at TIMEOUT_CYCLES.
- clear_i: clears order_err_o, timeout_o, err_count_o and the timeout counter; does not touch tag FIFO, outstanding or output registers. clear_i coincident with a timeout-fire cycle: clear wins, state stays RUN.
- Widths: outstanding_o spans 0..MAX_OUTSTANDING inclusive; tag FIFO pointers wrap modulo MAX_OUTSTANDING.

Test Plan:
- Single event: addr 0x0123 in, m_done_tdata=0x0123 one cycle later; completion {0x0123, err 0} -> m_ack_tdata=0x012300, outstanding 1->0, no flags.
- Fill: 16 addrs 0..15 with m_done_tready=1, no completions -> s_addr_tready low at outstanding=16; one completion of addr 0 -> tready high next cycle; 17th addr accepted.
- Order error: issue 0x10, 0x11; complete 0x11 first -> m_ack mismatch bit=1, tag_addr=0x10, order_err_o=1; clear_i -> 0.
- Errors: 3 completions with err=4'b0011 -> err_count_o=3, m_ack err field=3; completion with FIFO empty -> order_err_o=1, outstanding stays 0.
- Timeout (TIMEOUT_CYCLES=100): issue one addr, withhold completion -> timeout_o=1 at cycle 100, s_addr_tready=0; late completion still acked; clear_i -> issue resumes.
- Backpressure/reset: m_ack_tready=0 with two completions -> s_cmpl_tready drops after first, m_ack data stable; memrst mid-operation -> all valids 0, outstanding 0 next cycle.
